equiv_sweep_checker: RTL and testbench
======================================

# equiv_sweep_checker

Self-running exhaustive equivalence checker for two combinational implementations of the same Boolean function, such as an original form and its simplified form. After a start pulse it drives every N_IN-bit input combination, in ascending order, into both functions. It compares their outputs after a programmable settle time, counts mismatches and captures the first failing vector. The design is synthesizable, so the same sweep that a hand-written stimulus list performs in simulation can run on the board, with results shown on LEDs or seven-segment displays.

## Interface
- N_IN, 4: width of the input vector under test. The sweep covers 2^N_IN vectors.
- N_OUT, 1: width of each function's output.
- SETTLE, 0: extra cycles each vector is held before comparison. Range 0..15.
- clk  in  1  system clock. All state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep. Accepted only in IDLE or DONE.
- stop_on_fail  in  1  sampled when start is accepted. 1 = end the sweep at the first mismatch.
- stim  out  N_IN  current input vector, fed to both functions.
- ref_f  in  N_OUT  output of the reference (original) function.
- dut_f  in  N_OUT  output of the function under check (simplified).
- busy  out  1  a sweep is in progress.
- done  out  1  sweep finished. Held until the next accepted start or reset.
- pass  out  1  valid while done. 1 = no mismatch seen.
- mismatch_count  out  N_IN+1  number of vectors where ref_f != dut_f.
- first_fail_valid  out  1  at least one mismatch has been captured.
- first_fail_vec  out  N_IN  stim value of the first mismatch.

## Operation
- FSM states are IDLE, HOLD, CHECK and DONE.
- **IDLE:** all outputs are 0.
  - start=1 goes to HOLD.
  - On that transition: stim<=0, settle counter<=0, stop_on_fail is latched, mismatch_count and first_fail_* are cleared.
- **HOLD:** the settle counter increments each cycle. When the counter equals SETTLE, go to CHECK. With SETTLE=0, HOLD lasts 1 cycle.
- **CHECK:** lasts 1 cycle. It compares the full N_OUT-bit vectors ref_f and dut_f.
  - If they differ: mismatch_count is incremented.
  - If they differ and first_fail_valid=0: first_fail_vec<=stim and first_fail_valid<=1.
  - Go to DONE if stim is all ones, or if the vectors differ and the latched stop_on_fail=1.
  - Otherwise stim<=stim+1, the settle counter is cleared, and go to HOLD.
- **DONE:**
  - done=1, busy=0.
  - pass = (mismatch_count==0), evaluated on the updated count.
  - stim, mismatch_count and first_fail_* hold their values.
  - start=1 restarts exactly as from IDLE.
- busy=1 in HOLD and CHECK only.
- start while busy is ignored. It does not restart, extend or alter the sweep.
- stim never wraps during a sweep. The last vector checked is 2^N_IN-1.
- mismatch_count is N_IN+1 bits, so it holds the full 2^N_IN without overflow.
- reset overrides everything, including mid-sweep: the block returns to IDLE and every output goes to 0.

## Timing
- **Reset values:** stim=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_valid=0, first_fail_vec=0.
- **Start:**
  - Start is sampled at edge E0. At E0, busy rises and stim becomes 0.
  - Each vector occupies SETTLE+2 cycles: SETTLE+1 in HOLD and 1 in CHECK.
  - ref_f and dut_f are sampled at the edge that ends CHECK. The functions therefore have at least SETTLE+1 full cycles to settle after stim changes.
- **Done latency:**
  - A full sweep raises done at E0 + 2^N_IN*(SETTLE+2) cycles.
  - done and pass become valid on the same edge.
  - busy falls on that edge.
- **Early stop:** a stop_on_fail termination raises done at E0 + (k+1)*(SETTLE+2), where k is the failing vector index.
- **Restart:** start in DONE takes effect at the next edge. done falls and busy rises on that same edge.
- **Reset mid-sweep:** all outputs read 0 the cycle after the reset edge. A start on the first cycle after reset deasserts is accepted normally.

## Test plan
- **Identical functions:** N_IN=4, SETTLE=0, dut_f=ref_f, stop_on_fail=0. Required: done exactly 32 cycles after start, pass=1, mismatch_count=0, first_fail_valid=0, stim=15.
- **Two injected mismatches:** dut_f differs at stim=5 and stim=12, stop_on_fail=0. Required: mismatch_count=2, first_fail_vec=5, first_fail_valid=1, pass=0, done at 32 cycles.
- **Early stop:** same injection with stop_on_fail=1. Required: done 12 cycles after start, stim=5, mismatch_count=1, first_fail_vec=5.
- **Settle and count width:** SETTLE=2 with dut_f=~ref_f. Required: done 64 cycles after start, mismatch_count=16 (no wrap), first_fail_vec=0.
- **Reset mid-sweep:** assert reset while stim=7. Required: the next cycle shows all outputs 0. A fresh start then completes a clean 32-cycle sweep with pass=1.
- **Start pulses:** start pulsed while busy (stim=3). Required: no effect, done still at 32 cycles. A start in DONE restarts with the counters cleared and done falling at the next edge.

Source files
------------

// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker
// Exhaustive equivalence sweep: drives every input vector into two
// combinational implementations of the same function, compares their
// outputs after a settle time, counts mismatches and captures the first
// failing vector so the result can be shown on board indicators.

module equiv_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop_on_fail,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  ref_f,
    input  logic [N_OUT-1:0]  dut_f,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE);
    localparam logic [N_IN:0] COUNT_ONE   = (N_IN+1)'(1);
    localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);

    state_t      state;
    logic [3:0]  settle_cnt;
    logic        stop_latched;
    logic        differ;
    logic        last_vec;

    // Full-width comparison of the two implementations and end-of-range
    // detection, both consumed only while in CHECK.
    always_comb begin
        differ   = (ref_f != dut_f);
        last_vec = (stim == {N_IN{1'b1}});
    end

    // Sweep controller: every output is registered here so the board sees
    // glitch-free indicators, and reset wipes the whole result set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            settle_cnt       <= 4'd0;
            stop_latched     <= 1'b0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= HOLD;
                        settle_cnt       <= 4'd0;
                        stop_latched     <= stop_on_fail;
                        stim             <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_count   <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                HOLD: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (differ) begin
                        mismatch_count <= mismatch_count + COUNT_ONE;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= stim;
                        end
                    end
                    if (last_vec || (differ && stop_latched)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_count == '0) && !differ;
                    end else begin
                        stim       <= stim + STIM_ONE;
                        settle_cnt <= 4'd0;
                        state      <= HOLD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// tb_equiv_sweep_checker
// Scoreboard bench: each accepted start pushes the hand-computed result of
// that sweep; monitors pop and compare whenever a checker raises done.

module tb_equiv_sweep_checker;

    typedef struct {
        int lat;
        int pas;
        int cnt;
        int ffv;
        int ffvec;
        int stim;
        int e0;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0;
    logic       start2 = 1'b0;
    logic       sof0 = 1'b0;
    logic       inject = 1'b0;

    logic [3:0] stim0, stim2;
    logic [0:0] ref0, dutf0, ref2, dutf2;
    logic       busy0, done0, pass0, ffv0;
    logic       busy2, done2, pass2, ffv2;
    logic [4:0] cnt0, cnt2;
    logic [3:0] ffvec0, ffvec2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q2[$];
    logic dprev0 = 1'b0;
    logic dprev2 = 1'b0;

    // Reference function and its "simplified" copy; dutf0 can be corrupted
    // at vectors 5 and 12, dutf2 is always the complement.
    assign ref0  = (stim0[0] & stim0[1]) | (stim0[2] ^ stim0[3]);
    assign dutf0 = ref0 ^ {inject & ((stim0 == 4'd5) | (stim0 == 4'd12))};
    assign ref2  = (stim2[0] & stim2[1]) | (stim2[2] ^ stim2[3]);
    assign dutf2 = ~ref2;

    equiv_sweep_checker #(.N_IN(4), .N_OUT(1), .SETTLE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .stop_on_fail(sof0),
        .stim(stim0), .ref_f(ref0), .dut_f(dutf0), .busy(busy0), .done(done0),
        .pass(pass0), .mismatch_count(cnt0), .first_fail_valid(ffv0),
        .first_fail_vec(ffvec0)
    );

    equiv_sweep_checker #(.N_IN(4), .N_OUT(1), .SETTLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop_on_fail(1'b0),
        .stim(stim2), .ref_f(ref2), .dut_f(dutf2), .busy(busy2), .done(done2),
        .pass(pass2), .mismatch_count(cnt2), .first_fail_valid(ffv2),
        .first_fail_vec(ffvec2)
    );

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drives a start pulse from just after a falling edge and records the
    // accepting edge E0 with the expected outcome of the sweep.
    task automatic applyStimulus(input int which, input logic sof, input logic inj,
                                 input exp_t e, input bit restart_chk);
        exp_t x;
        x = e;
        inject = inj;
        if (which == 0) begin
            sof0 = sof;
            start0 = 1'b1;
        end else begin
            start2 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        x.e0 = cyc;
        if (which == 0) q0.push_back(x);
        else q2.push_back(x);
        if (restart_chk) begin
            checkOutput("restart_done", int'(done0), 0);
            checkOutput("restart_busy", int'(busy0), 1);
            checkOutput("restart_count", int'(cnt0), 0);
            checkOutput("restart_ffv", int'(ffv0), 0);
        end
    endtask

    task automatic waitDrain(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q2.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout%0d: got pending expected none", which);
        end
    endtask

    task automatic waitStim(input int val, input int budget);
        int n;
        n = 0;
        while (int'(stim0) != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL stim_timeout: got %0d expected %0d", stim0, val);
        end
    endtask

    task automatic compareDone(input string tag, input exp_t e, input int lat,
                               input int p, input int c, input int fv,
                               input int fvec, input int s, input int b);
        checkOutput({tag, "_latency"}, lat, e.lat);
        checkOutput({tag, "_pass"}, p, e.pas);
        checkOutput({tag, "_count"}, c, e.cnt);
        checkOutput({tag, "_ffv"}, fv, e.ffv);
        checkOutput({tag, "_ffvec"}, fvec, e.ffvec);
        checkOutput({tag, "_stim"}, s, e.stim);
        checkOutput({tag, "_busy"}, b, 0);
    endtask

    // Monitors: compare against the oldest pending expectation whenever a
    // checker raises done.
    always @(negedge clk) begin
        exp_t e;
        if (done0 && !dprev0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done0: got done expected none");
            end else begin
                e = q0.pop_front();
                compareDone("s0", e, cyc - e.e0, int'(pass0), int'(cnt0),
                            int'(ffv0), int'(ffvec0), int'(stim0), int'(busy0));
            end
        end
        dprev0 = done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2 && !dprev2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done2: got done expected none");
            end else begin
                e = q2.pop_front();
                compareDone("s2", e, cyc - e.e0, int'(pass2), int'(cnt2),
                            int'(ffv2), int'(ffvec2), int'(stim2), int'(busy2));
            end
        end
        dprev2 = done2;
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stim"}, int'(stim0), 0);
        checkOutput({tag, "_busy"}, int'(busy0), 0);
        checkOutput({tag, "_done"}, int'(done0), 0);
        checkOutput({tag, "_pass"}, int'(pass0), 0);
        checkOutput({tag, "_count"}, int'(cnt0), 0);
        checkOutput({tag, "_ffv"}, int'(ffv0), 0);
        checkOutput({tag, "_ffvec"}, int'(ffvec0), 0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        checkOutput("reset_done2", int'(done2), 0);
        reset = 1'b0;

        // SETTLE=2 with complemented function: 16 vectors x 4 cycles.
        e = '{lat: 64, pas: 0, cnt: 16, ffv: 1, ffvec: 0, stim: 15, e0: 0};
        applyStimulus(2, 1'b0, 1'b0, e, 1'b0);

        // Identical functions, with a stray start pulse mid-sweep.
        e = '{lat: 32, pas: 1, cnt: 0, ffv: 0, ffvec: 0, stim: 15, e0: 0};
        applyStimulus(0, 1'b0, 1'b0, e, 1'b0);
        waitStim(3, 40);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitDrain(0, 60);

        // Restart from DONE with mismatches injected at 5 and 12.
        e = '{lat: 32, pas: 0, cnt: 2, ffv: 1, ffvec: 5, stim: 15, e0: 0};
        applyStimulus(0, 1'b0, 1'b1, e, 1'b1);
        waitDrain(0, 60);

        // Same injection, stopping at the first mismatch: (5+1)*2 cycles.
        e = '{lat: 12, pas: 0, cnt: 1, ffv: 1, ffvec: 5, stim: 5, e0: 0};
        applyStimulus(0, 1'b1, 1'b1, e, 1'b0);
        waitDrain(0, 60);
        waitDrain(2, 100);

        // Reset mid-sweep, then a start on the very first free cycle.
        e = '{lat: 32, pas: 1, cnt: 0, ffv: 0, ffvec: 0, stim: 15, e0: 0};
        applyStimulus(0, 1'b0, 1'b0, e, 1'b0);
        waitStim(7, 40);
        reset = 1'b1;
        @(negedge clk);
        q0.delete();
        checkAllZero("midreset");
        reset = 1'b0;
        e = '{lat: 32, pas: 1, cnt: 0, ffv: 0, ffvec: 0, stim: 15, e0: 0};
        applyStimulus(0, 1'b0, 1'b0, e, 1'b0);
        waitDrain(0, 60);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
